// File: rtl/gate_tt_sweep_ctrl.sv
// rtl/gate_tt_sweep_ctrl.sv - built-in self-test sequencer that sweeps a 2-input cell and checks its truth table
module gate_tt_sweep_ctrl #(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 8
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic       abort_i,
    input  logic [3:0] expected_i,
    input  logic       c_i,
    output logic       a_o,
    output logic       b_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       pass_o,
    output logic [3:0] observed_o,
    output logic [3:0] mismatch_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    state_t           state_q, state_d;
    logic [1:0]       ab_q, ab_d;
    logic [1:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       exp_q, exp_d;
    logic [3:0]       obs_q, obs_d;
    logic [3:0]       mis_q, mis_d;
    logic             pass_q, pass_d;
    logic [3:0]       obs_smp;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            ab_q    <= 2'b00;
            idx_q   <= 2'd0;
            cnt_q   <= '0;
            exp_q   <= 4'b0000;
            obs_q   <= 4'b0000;
            mis_q   <= 4'b0000;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ab_q    <= ab_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            exp_q   <= exp_d;
            obs_q   <= obs_d;
            mis_q   <= mis_d;
            pass_q  <= pass_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ab_d    = ab_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        exp_d   = exp_q;
        obs_d   = obs_q;
        mis_d   = mis_q;
        pass_d  = pass_q;

        // Observed table including the bit captured at the end of the current SAMPLE cycle
        obs_smp         = obs_q;
        obs_smp[idx_q]  = c_i;

        case (state_q)
            ST_IDLE: begin
                ab_d = 2'b00;
                if (start_i && !abort_i) begin
                    exp_d   = expected_i;
                    obs_d   = 4'b0000;
                    mis_d   = 4'b0000;
                    pass_d  = 1'b0;
                    idx_d   = 2'd0;
                    cnt_d   = '0;
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (abort_i) begin
                    ab_d    = 2'b00;
                    pass_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == SETTLE_LAST) begin
                        state_d = ST_SAMPLE;
                    end
                end
            end
            ST_SAMPLE: begin
                if (abort_i) begin
                    // Pending sample is dropped; earlier captures are kept
                    ab_d    = 2'b00;
                    pass_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    obs_d = obs_smp;
                    if (idx_q == 2'd3) begin
                        mis_d   = obs_smp ^ exp_q;
                        pass_d  = ((obs_smp ^ exp_q) == 4'b0000);
                        ab_d    = 2'b00;
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        ab_d    = idx_q + 2'd1;
                        cnt_d   = '0;
                        state_d = ST_SETTLE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign a_o        = ab_q[1];
    assign b_o        = ab_q[0];
    assign busy_o     = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
    assign done_o     = (state_q == ST_DONE);
    assign pass_o     = pass_q;
    assign observed_o = obs_q;
    assign mismatch_o = mis_q;

endmodule

// File: tb/tb_gate_tt_sweep_ctrl.sv
// tb/tb_gate_tt_sweep_ctrl.sv - randomized self-checking bench for gate_tt_sweep_ctrl
module tb_gate_tt_sweep_ctrl;

    localparam int S = 2;
    localparam int L = 4 * (S + 1);

    logic       clk = 1'b0;
    logic       rst;
    logic       start, abort;
    logic [3:0] expected;
    logic       a, b, c, busy, done, pass;
    logic [3:0] obs, mis;

    logic       start5, abort5;
    logic [3:0] expected5;
    logic       a5, b5, c5, busy5, done5, pass5;
    logic [3:0] obs5, mis5;

    logic [3:0] cell_tt;
    int         vectors = 0;
    int         miscompares = 0;

    always #5 clk = ~clk;

    assign c  = cell_tt[{a, b}];
    assign c5 = cell_tt[{a5, b5}];

    gate_tt_sweep_ctrl #(.SETTLE_CYCLES(S), .CNT_W(8)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort),
        .expected_i(expected), .c_i(c), .a_o(a), .b_o(b), .busy_o(busy),
        .done_o(done), .pass_o(pass), .observed_o(obs), .mismatch_o(mis)
    );

    gate_tt_sweep_ctrl #(.SETTLE_CYCLES(5), .CNT_W(8)) dut5 (
        .clk_i(clk), .rst_i(rst), .start_i(start5), .abort_i(abort5),
        .expected_i(expected5), .c_i(c5), .a_o(a5), .b_o(b5), .busy_o(busy5),
        .done_o(done5), .pass_o(pass5), .observed_o(obs5), .mismatch_o(mis5)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full sweep with per-cycle checks; expectations come from the truth-table model
    task automatic run_checked_sweep(input string name, input logic [3:0] tt, input logic [3:0] ex);
        logic [3:0] want_obs, want_mis;
        logic       want_pass;
        cell_tt  = tt;
        expected = ex;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        for (int m = 0; m < L; m++) begin
            logic [1:0] vec;
            vec = 2'(m / (S + 1));
            vectors++;
            if ({a, b, busy, done, pass} !== {vec, 1'b1, 1'b0, 1'b0}) begin
                miscompares++;
                $display("FAIL %s cycle%0d: a,b,busy,done,pass=%b required %b", name, m,
                         {a, b, busy, done, pass}, {vec, 3'b100});
            end
            tick();
        end
        want_obs  = tt;
        want_mis  = tt ^ ex;
        want_pass = (tt == ex);
        vectors++;
        if ({done, busy, a, b, obs, mis, pass} !== {1'b1, 3'b000, want_obs, want_mis, want_pass}) begin
            miscompares++;
            $display("FAIL %s result: done,busy,a,b,obs,mis,pass=%b required %b", name,
                     {done, busy, a, b, obs, mis, pass}, {4'b1000, want_obs, want_mis, want_pass});
        end
        tick();
        vectors++;
        if ({done, busy, pass, obs} !== {2'b00, want_pass, want_obs}) begin
            miscompares++;
            $display("FAIL %s after_done: done,busy,pass,obs=%b required %b", name,
                     {done, busy, pass, obs}, {2'b00, want_pass, want_obs});
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #3;
        vectors++;
        if ({a, b, busy, done, pass, obs, mis} !== 15'd0) begin
            miscompares++;
            $display("FAIL reset: outputs=%b required 0", {a, b, busy, done, pass, obs, mis});
        end
        #9 rst = 1'b0;
        tick();
        vectors++;
        if ({a, b, busy, done, a5, b5, busy5, done5} !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_release: outputs=%b required 0", {a, b, busy, done, a5, b5, busy5, done5});
        end
    endtask

    task automatic test_xor();
        run_checked_sweep("xor", 4'b0110, 4'b0110);
    endtask

    task automatic test_and();
        run_checked_sweep("and", 4'b1000, 4'b0110);
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            run_checked_sweep("random", 4'($urandom), 4'($urandom));
        end
    endtask

    task automatic test_settle5();
        int n;
        cell_tt   = 4'b1000;
        expected5 = 4'b0110;
        start5    = 1'b1;
        tick();
        start5    = 1'b0;
        n = 0;
        while (!done5 && n < 100) begin
            tick();
            n++;
        end
        vectors++;
        if (n !== 24) begin
            miscompares++;
            $display("FAIL settle5_latency: done at edge %0d required 24", n);
        end
        vectors++;
        if ({obs5, mis5, pass5} !== {4'b1000, 4'b1110, 1'b0}) begin
            miscompares++;
            $display("FAIL settle5_result: obs,mis,pass=%b required %b", {obs5, mis5, pass5}, 9'b100011100);
        end
        tick();
    endtask

    task automatic test_abort();
        logic [3:0] tt;
        int         seen_done;
        tt       = 4'($urandom);
        cell_tt  = tt;
        expected = 4'($urandom);
        start    = 1'b1;
        tick();
        start    = 1'b0;
        // Move to the SAMPLE cycle of vector 2
        for (int m = 0; m < 2 * (S + 1) + S; m++) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        vectors++;
        if ({busy, a, b, done, pass, obs, mis} !== {5'b00000, tt & 4'b0011, 4'b0000}) begin
            miscompares++;
            $display("FAIL abort: busy,a,b,done,pass,obs,mis=%b required %b",
                     {busy, a, b, done, pass, obs, mis}, {5'b00000, tt & 4'b0011, 4'b0000});
        end
        seen_done = 0;
        for (int m = 0; m < L; m++) begin
            tick();
            if (done || busy) seen_done++;
        end
        vectors++;
        if (seen_done !== 0) begin
            miscompares++;
            $display("FAIL abort_quiet: active cycles=%0d required 0", seen_done);
        end
    endtask

    task automatic test_ignored_requests();
        int dones, done_edge;
        cell_tt  = 4'b0110;
        expected = 4'b0110;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        dones = 0;
        done_edge = -1;
        for (int m = 1; m <= L + 8; m++) begin
            start = (m == 3) || (m == 7);
            tick();
            if (done) begin
                dones++;
                done_edge = m;
            end
        end
        start = 1'b0;
        vectors++;
        if (dones !== 1 || done_edge !== L) begin
            miscompares++;
            $display("FAIL busy_start: dones=%0d at edge %0d required 1 at %0d", dones, done_edge, L);
        end
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL start_abort_idle: busy=%b required 0", busy);
        end
        run_checked_sweep("pre_done_start", 4'b0110, 4'b0110);
        // Rerun to sit in DONE, then hold start through DONE and into IDLE
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int m = 0; m < L; m++) tick();
        vectors++;
        if (done !== 1'b1) begin
            miscompares++;
            $display("FAIL done_reach: done=%b required 1", done);
        end
        start = 1'b1;
        tick();
        vectors++;
        if ({busy, pass, obs} !== {1'b0, 1'b1, 4'b0110}) begin
            miscompares++;
            $display("FAIL done_start_ignored: busy,pass,obs=%b required 010110", {busy, pass, obs});
        end
        tick();
        start = 1'b0;
        vectors++;
        if ({busy, pass, obs} !== {1'b1, 1'b0, 4'b0000}) begin
            miscompares++;
            $display("FAIL idle_start_accept: busy,pass,obs=%b required 100000", {busy, pass, obs});
        end
        for (int m = 0; m < L + 2; m++) tick();
    endtask

    task automatic test_async_reset();
        cell_tt  = 4'b0110;
        expected = 4'b0110;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        for (int m = 0; m < S + 1; m++) tick();
        #2 rst = 1'b1;
        #1;
        vectors++;
        if ({a, b, busy, done, pass, obs, mis} !== 15'd0) begin
            miscompares++;
            $display("FAIL async_reset: outputs=%b required 0", {a, b, busy, done, pass, obs, mis});
        end
        #3 rst = 1'b0;
        tick();
        run_checked_sweep("post_reset", 4'b0110, 4'b0110);
    endtask

    task automatic test_expected_change();
        int n;
        cell_tt  = 4'b0110;
        expected = 4'b0110;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        tick();
        expected = 4'b0000;
        n = 1;
        while (!done && n < 100) begin
            tick();
            n++;
        end
        vectors++;
        if ({n == L, pass, mis} !== {1'b1, 1'b1, 4'b0000}) begin
            miscompares++;
            $display("FAIL expected_latched: edge=%0d pass=%b mis=%b required edge %0d pass 1 mis 0000", n, pass, mis, L);
        end
        tick();
    endtask

    initial begin
        start = 1'b0; abort = 1'b0; expected = 4'b0000;
        start5 = 1'b0; abort5 = 1'b0; expected5 = 4'b0000;
        cell_tt = 4'b0110;
        test_reset();
        test_xor();
        test_and();
        test_settle5();
        test_random();
        test_abort();
        test_ignored_requests();
        test_async_reset();
        test_expected_change();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
